// File: rtl/cla16_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit carry-look-ahead adder among NREQ requesters,
// with carry chaining for multi-word adds. Optional busy counter: CLA16_ARB_PERF_EN.
module cla16_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]    req_last,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_sum,
  output logic               rsp_cout,
  output logic               rsp_last
`ifdef CLA16_ARB_PERF_EN
  ,
  output logic [31:0]        busy_cycles
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr, rr_d;
  logic [IDW-1:0] lock_id, lock_d;
  logic           carry_q, carry_d;

  logic [IDW-1:0] grant;
  logic [IDW-1:0] grant_next;
  logic [IDW:0]   scan;
  logic           found;
  logic           slot_free;
  logic           accept;

  logic [15:0]    op_x, op_y, sum;
  logic           cin, cout, sel_last;
  logic [15:0]    g, p;
  logic [3:0]     gg, gp;
  logic [4:0]     gc;
  logic [16:0]    c;

  // Grant search: locked requester in LOCK, otherwise first valid at or after rr_ptr.
  always_comb begin
    grant = (state_q == LOCK) ? lock_id : rr_ptr;
    found = 1'b0;
    scan  = '0;
    if (state_q == IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        scan = {1'b0, rr_ptr} + (IDW+1)'(k);
        if (scan >= (IDW+1)'(NREQ))
          scan = scan - (IDW+1)'(NREQ);
        if (!found && req_valid[scan[IDW-1:0]]) begin
          found = 1'b1;
          grant = scan[IDW-1:0];
        end
      end
    end
  end

  assign slot_free  = !rsp_valid || rsp_ready;
  assign accept     = !rst && slot_free && req_valid[grant];
  assign grant_next = (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[grant] = 1'b1;
  end

  assign op_x     = req_x[16*grant +: 16];
  assign op_y     = req_y[16*grant +: 16];
  assign sel_last = req_last[grant];
  assign cin      = (state_q == LOCK) ? carry_q : 1'b0;

  // Two-level look-ahead: 4-bit group generate/propagate, then group carries from cin.
  always_comb begin
    g = op_x & op_y;
    p = op_x ^ op_y;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
    end
    c[16] = gc[4];
    sum   = p ^ c[15:0];
    cout  = c[16];
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_id;
    rr_d    = rr_ptr;
    carry_d = carry_q;
    if (accept) begin
      if (sel_last) begin
        state_d = IDLE;
        rr_d    = grant_next;
        carry_d = 1'b0;
      end else begin
        state_d = LOCK;
        lock_d  = grant;
        carry_d = cout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr  <= rr_d;
      lock_id <= lock_d;
      carry_q <= carry_d;
    end
  end

  // Response register: loads on accept, otherwise holds until drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant;
      rsp_sum   <= sum;
      rsp_cout  <= cout;
      rsp_last  <= sel_last;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef CLA16_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_cycles <= '0;
    else
      busy_cycles <= busy_cycles + 32'(accept);
  end
`endif

endmodule
